// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and default widths for the DRAM request arbiter.
package dram_arb_pkg;
   typedef enum logic [1:0] {CALIB, IDLE, ISSUE, RWAIT} arb_state_t;
   typedef logic port_id_t;
   typedef enum logic {OP_RD, OP_WR} op_t;
   localparam int DEF_APP_ADDR_WIDTH = 28;
   localparam int DEF_APP_DATA_WIDTH = 128;
   localparam int DEF_APP_MASK_WIDTH = 16;
   localparam int DEF_RD_TIMEOUT     = 1023;
endpackage

// File: rtl/dram_arb_rr2.sv
// dram_arb_rr2: two-way round-robin pick; a tie goes to the port not granted last.
module dram_arb_rr2
   import dram_arb_pkg::*;
(
   input  logic [1:0] pending_i,
   input  port_id_t   last_grant_i,
   output logic       valid_o,
   output port_id_t   sel_o
);
   always_comb begin
      valid_o = |pending_i;
      sel_o   = &pending_i ? ~last_grant_i : pending_i[1];
   end
endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: shares one DRAM user interface between two requesters, one command in flight,
// read data routed back to its issuer and lost reads turned into error completions.
module dram_req_arbiter
   import dram_arb_pkg::*;
#(
   parameter int APP_ADDR_WIDTH = DEF_APP_ADDR_WIDTH,
   parameter int APP_DATA_WIDTH = DEF_APP_DATA_WIDTH,
   parameter int APP_MASK_WIDTH = DEF_APP_MASK_WIDTH,
   parameter int RD_TIMEOUT     = DEF_RD_TIMEOUT
) (
   input  logic                      clk_166_67_mhz,
   input  logic                      dram_rstx_async,
   input  logic                      p0_ren_i,
   input  logic                      p0_wen_i,
   input  logic [APP_ADDR_WIDTH-2:0] p0_addr_i,
   input  logic [APP_DATA_WIDTH-1:0] p0_wdata_i,
   input  logic [APP_MASK_WIDTH-1:0] p0_wmask_i,
   output logic                      p0_ack_o,
   output logic [APP_DATA_WIDTH-1:0] p0_rdata_o,
   output logic                      p0_rvalid_o,
   output logic                      p0_rerr_o,
   input  logic                      p1_ren_i,
   input  logic                      p1_wen_i,
   input  logic [APP_ADDR_WIDTH-2:0] p1_addr_i,
   input  logic [APP_DATA_WIDTH-1:0] p1_wdata_i,
   input  logic [APP_MASK_WIDTH-1:0] p1_wmask_i,
   output logic                      p1_ack_o,
   output logic [APP_DATA_WIDTH-1:0] p1_rdata_o,
   output logic                      p1_rvalid_o,
   output logic                      p1_rerr_o,
   output logic                      dram_ren_o,
   output logic                      dram_wen_o,
   output logic [APP_ADDR_WIDTH-2:0] dram_addr_o,
   output logic [APP_DATA_WIDTH-1:0] dram_wdata_o,
   output logic [APP_MASK_WIDTH-1:0] dram_wmask_o,
   input  logic                      dram_init_calib_complete_i,
   input  logic                      dram_busy_i,
   input  logic [APP_DATA_WIDTH-1:0] dram_rdata_i,
   input  logic                      dram_rdata_valid_i
);
   localparam logic [15:0] TIMEOUT = 16'(RD_TIMEOUT);

   arb_state_t                state_q, state_d;
   port_id_t                  owner_q, owner_d, last_q, last_d, sel;
   op_t                       op_q, op_d;
   logic                      grant, done;
   logic [APP_ADDR_WIDTH-2:0] addr_q, addr_d;
   logic [APP_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d, rdata_new;
   logic [APP_MASK_WIDTH-1:0] wmask_q, wmask_d;
   logic                      ren_q, ren_d, wen_q, wen_d;
   logic [1:0]                ack_q, ack_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
   logic [15:0]               cnt_q, cnt_d;

   dram_arb_rr2 u_rr2 (
      .pending_i    ({p1_ren_i | p1_wen_i, p0_ren_i | p0_wen_i}),
      .last_grant_i (last_q),
      .valid_o      (grant),
      .sel_o        (sel)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      ren_d     = ren_q;
      wen_d     = wen_q;
      ack_d     = '0;
      rvalid_d  = '0;
      rerr_d    = '0;
      cnt_d     = cnt_q;
      done      = 1'b0;
      rdata_new = dram_rdata_valid_i ? dram_rdata_i : '0;
      case (state_q)
         CALIB: state_d = dram_init_calib_complete_i ? IDLE : CALIB;
         IDLE:
            if (!dram_init_calib_complete_i) state_d = CALIB;
            else if (grant) begin
               owner_d    = sel;
               last_d     = sel;
               op_d       = (sel ? p1_wen_i : p0_wen_i) ? OP_WR : OP_RD;
               addr_d     = sel ? p1_addr_i : p0_addr_i;
               wdata_d    = sel ? p1_wdata_i : p0_wdata_i;
               wmask_d    = sel ? p1_wmask_i : p0_wmask_i;
               ren_d      = op_d == OP_RD;
               wen_d      = op_d == OP_WR;
               ack_d[sel] = 1'b1;
               state_d    = ISSUE;
            end
         ISSUE:
            if (!dram_busy_i) begin
               ren_d   = 1'b0;
               wen_d   = 1'b0;
               cnt_d   = '0;
               state_d = op_q == OP_WR ? IDLE : RWAIT;
            end
         RWAIT: begin
            cnt_d = cnt_q + 16'd1;
            // real data beats the watchdog when both land in the same cycle
            done  = dram_rdata_valid_i || cnt_q == TIMEOUT;
            if (done) begin
               rvalid_d[owner_q] = 1'b1;
               rerr_d[owner_q]   = !dram_rdata_valid_i;
               state_d           = IDLE;
            end
         end
         default: state_d = CALIB;
      endcase
   end

   assign rdata0_d = (done && !owner_q) ? rdata_new : rdata0_q;
   assign rdata1_d = (done && owner_q) ? rdata_new : rdata1_q;

   always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
      if (!dram_rstx_async) begin
         state_q  <= CALIB;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         op_q     <= OP_RD;
         addr_q   <= '0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         ack_q    <= '0;
         rvalid_q <= '0;
         rerr_q   <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         ack_q    <= ack_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         cnt_q    <= cnt_d;
      end
   end

   assign p0_ack_o     = ack_q[0];
   assign p1_ack_o     = ack_q[1];
   assign p0_rvalid_o  = rvalid_q[0];
   assign p1_rvalid_o  = rvalid_q[1];
   assign p0_rerr_o    = rerr_q[0];
   assign p1_rerr_o    = rerr_q[1];
   assign p0_rdata_o   = rdata0_q;
   assign p1_rdata_o   = rdata1_q;
   assign dram_ren_o   = ren_q;
   assign dram_wen_o   = wen_q;
   assign dram_addr_o  = addr_q;
   assign dram_wdata_o = wdata_q;
   assign dram_wmask_o = wmask_q;
endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: directed scenarios against a transaction-level model of the arbiter,
// checked every cycle, plus hand-computed literal expectations.
module tb_dram_req_arbiter;
   localparam int AW = 27, DW = 128, MW = 16, TO = 8;

   logic clk = 1'b0, rstn = 1'b1;
   logic p0_ren = 1'b0, p0_wen = 1'b0, p1_ren = 1'b0, p1_wen = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic [MW-1:0] p0_wmask = '0, p1_wmask = '0;
   logic calib = 1'b0, busy = 1'b0, rdv = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic p0_ack, p0_rvalid, p0_rerr, p1_ack, p1_rvalid, p1_rerr, dram_ren, dram_wen;
   logic [DW-1:0] p0_rdata, p1_rdata, dram_wdata;
   logic [AW-1:0] dram_addr;
   logic [MW-1:0] dram_wmask;

   dram_req_arbiter #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .RD_TIMEOUT(TO)) dut (
      .clk_166_67_mhz(clk), .dram_rstx_async(rstn),
      .p0_ren_i(p0_ren), .p0_wen_i(p0_wen), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_wmask_i(p0_wmask),
      .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata), .p0_rvalid_o(p0_rvalid), .p0_rerr_o(p0_rerr),
      .p1_ren_i(p1_ren), .p1_wen_i(p1_wen), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_wmask_i(p1_wmask),
      .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata), .p1_rvalid_o(p1_rvalid), .p1_rerr_o(p1_rerr),
      .dram_ren_o(dram_ren), .dram_wen_o(dram_wen), .dram_addr_o(dram_addr), .dram_wdata_o(dram_wdata),
      .dram_wmask_o(dram_wmask), .dram_init_calib_complete_i(calib), .dram_busy_i(busy),
      .dram_rdata_i(rdata), .dram_rdata_valid_i(rdv)
   );

   always #3 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0, resp_at = -1, resp_delay = 3, stray_at = -1, cur_port = 0, acc_cnt = 0, acc_cyc = 0;
   logic [DW-1:0] resp_val = '0;
   bit m_cal = 0, m_txn = 0, m_cmd = 0, m_last = 1, m_own = 0, m_wr = 0;
   int m_tacc = 0;
   logic [1:0] e_ack = '0, e_rv = '0, e_re = '0;
   logic e_ren = 0, e_wen = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_rd0 = '0, e_rd1 = '0;
   logic [MW-1:0] e_wmask = '0;
   int ack_log[$], rv_port[$], rv_cyc[$];
   bit rv_err[$];
   logic [DW-1:0] rv_data[$];
   int n_ren = 0, n_wen = 0, n_wen_ok = 0;
   logic [AW-1:0] w_addr = '0;
   logic [DW-1:0] w_data = '0;
   logic [MW-1:0] w_mask = '0;

   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   // Transaction-level model: a granted request owns the interface until its command is
   // accepted (writes) or its read returns / ages TO+1 edges past acceptance.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_cal = 0; m_txn = 0; m_cmd = 0; m_last = 1; m_own = 0; m_wr = 0; m_tacc = 0;
         e_ack = '0; e_rv = '0; e_re = '0; e_ren = 0; e_wen = 0;
         e_addr = '0; e_wdata = '0; e_wmask = '0; e_rd0 = '0; e_rd1 = '0;
         resp_at = -1; cur_port = 0;
      end else begin
         cyc++;
         if (p0_ack) cur_port = 0;
         if (p1_ack) cur_port = 1;
         if ((dram_ren || dram_wen) && !busy) begin
            acc_cnt++;
            acc_cyc = cyc;
            if (dram_ren) begin
               resp_at  = cyc + resp_delay;
               resp_val = cur_port ? 128'h0B : 128'h0A;
            end
         end
         e_ack = '0; e_rv = '0; e_re = '0;
         if (!m_cal) m_cal = calib;
         else if (!m_txn) begin
            if (!calib) m_cal = 0;
            else if (p0_ren | p0_wen | p1_ren | p1_wen) begin
               m_own = ((p0_ren | p0_wen) && (p1_ren | p1_wen)) ? !m_last : (p1_ren | p1_wen);
               m_last = m_own; m_txn = 1; m_cmd = 1;
               m_wr    = m_own ? p1_wen : p0_wen;
               e_addr  = m_own ? p1_addr : p0_addr;
               e_wdata = m_own ? p1_wdata : p0_wdata;
               e_wmask = m_own ? p1_wmask : p0_wmask;
               e_ack[m_own] = 1'b1;
            end
         end else if (m_cmd) begin
            if (!busy) begin
               m_cmd = 0; m_tacc = cyc;
               if (m_wr) m_txn = 0;
            end
         end else if (rdv || cyc - m_tacc == TO + 1) begin
            e_rv[m_own] = 1'b1;
            e_re[m_own] = !rdv;
            if (m_own) e_rd1 = rdv ? rdata : '0;
            else e_rd0 = rdv ? rdata : '0;
            m_txn = 0;
         end
         e_ren = m_cmd && !m_wr;
         e_wen = m_cmd && m_wr;
      end
   end

   always @(negedge clk) begin
      rdv   = (cyc + 1 == resp_at) || (cyc + 1 == stray_at);
      rdata = (cyc + 1 == resp_at) ? resp_val : (rdv ? 128'hDEAD : '0);
   end

   always @(negedge clk) if (rstn) begin
      chk("p0_ack", p0_ack, e_ack[0]);
      chk("p1_ack", p1_ack, e_ack[1]);
      chk("p0_rvalid", p0_rvalid, e_rv[0]);
      chk("p1_rvalid", p1_rvalid, e_rv[1]);
      chk("p0_rerr", p0_rerr, e_re[0]);
      chk("p1_rerr", p1_rerr, e_re[1]);
      chk("p0_rdata", p0_rdata, e_rd0);
      chk("p1_rdata", p1_rdata, e_rd1);
      chk("dram_ren", dram_ren, e_ren);
      chk("dram_wen", dram_wen, e_wen);
      chk("dram_addr", dram_addr, e_addr);
      chk("dram_wdata", dram_wdata, e_wdata);
      chk("dram_wmask", dram_wmask, e_wmask);
      if (p0_ack) ack_log.push_back(0);
      if (p1_ack) ack_log.push_back(1);
      if (p0_rvalid) begin rv_port.push_back(0); rv_err.push_back(p0_rerr); rv_data.push_back(p0_rdata); rv_cyc.push_back(cyc); end
      if (p1_rvalid) begin rv_port.push_back(1); rv_err.push_back(p1_rerr); rv_data.push_back(p1_rdata); rv_cyc.push_back(cyc); end
      if (dram_ren) n_ren++;
      if (dram_wen) n_wen++;
      if (dram_wen && dram_addr == w_addr && dram_wdata == w_data && dram_wmask == w_mask) n_wen_ok++;
   end

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic wait_ack(input string n);
      int b = ack_log.size();
      for (int i = 0; i < 100 && ack_log.size() == b; i++) step(1);
      chk({n, "_ack_seen"}, ack_log.size() > b, 1);
   endtask

   task automatic wait_rv(input string n, input int b);
      for (int i = 0; i < 100 && rv_port.size() == b; i++) step(1);
      chk({n, "_rvalid_seen"}, rv_port.size() > b, 1);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_ctl"}, {p0_ack, p1_ack, p0_rvalid, p1_rvalid, p0_rerr, p1_rerr, dram_ren, dram_wen}, 0);
      chk({n, "_p0_rdata"}, p0_rdata, 0);
      chk({n, "_p1_rdata"}, p1_rdata, 0);
      chk({n, "_dram_addr_mask"}, {dram_addr, dram_wmask}, 0);
      chk({n, "_dram_wdata"}, dram_wdata, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int b, rb, s_wen, s_ok, s_acc, s_ren;
      #1 rstn = 1'b0;
      step(3);
      chk_zero("reset");
      rstn = 1'b1;
      // calibration gate
      p0_addr = 27'h0ABCDEF; p0_ren = 1'b1;
      s_ren = n_ren; b = ack_log.size();
      step(50);
      chk("calib_gate_acks", ack_log.size() - b, 0);
      chk("calib_gate_ren", n_ren - s_ren, 0);
      calib = 1'b1;
      step(1);
      chk("calib_ack_early", p0_ack, 0);
      step(1);
      chk("calib_ack", p0_ack, 1);
      chk("calib_ren", dram_ren, 1);
      chk("calib_addr", dram_addr, 27'h0ABCDEF);
      p0_ren = 1'b0;
      rb = rv_port.size();
      wait_rv("calib_rd", rb);
      chk("calib_rd_data", rv_data[rb], 128'h0A);
      step(3);
      // busy backpressure on a p1 write
      w_addr = 27'h1234567; w_mask = 16'h00FF; w_data = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
      p1_addr = w_addr; p1_wmask = w_mask; p1_wdata = w_data;
      s_wen = n_wen; s_ok = n_wen_ok; s_acc = acc_cnt; b = ack_log.size();
      busy = 1'b1; p1_wen = 1'b1;
      wait_ack("busy");
      p1_wen = 1'b0;
      step(5);
      busy = 1'b0;
      step(5);
      chk("busy_wen_cycles", n_wen - s_wen, 6);
      chk("busy_stable_payload", n_wen_ok - s_ok, 6);
      chk("busy_accepts", acc_cnt - s_acc, 1);
      chk("busy_ack_count", ack_log.size() - b, 1);
      chk("busy_ack_port", ack_log[b], 1);
      // contention: continuous reads from both ports
      b = ack_log.size(); rb = rv_port.size();
      p0_addr = 27'h0000100; p1_addr = 27'h0000200; p0_ren = 1'b1; p1_ren = 1'b1;
      for (int i = 0; i < 300 && ack_log.size() < b + 4; i++) step(1);
      p0_ren = 1'b0; p1_ren = 1'b0;
      chk("cont_acks", ack_log.size() >= b + 4, 1);
      for (int i = 0; i < 100 && rv_port.size() < rb + 4; i++) step(1);
      chk("cont_rvalids", rv_port.size() >= rb + 4, 1);
      for (int i = 0; i < 4; i++) begin
         if (ack_log.size() > b + i) chk($sformatf("cont_ack_%0d", i), ack_log[b + i], i % 2);
         if (rv_port.size() > rb + i) begin
            chk($sformatf("cont_rv_port_%0d", i), rv_port[rb + i], i % 2);
            chk($sformatf("cont_rv_data_%0d", i), rv_data[rb + i], (i % 2) ? 128'h0B : 128'h0A);
            chk($sformatf("cont_rv_err_%0d", i), rv_err[rb + i], 0);
         end
      end
      step(3);
      // read timeout and a late stray response
      resp_delay = 100000;
      rb = rv_port.size();
      p0_addr = 27'h0000300; p0_ren = 1'b1;
      wait_ack("to");
      p0_ren = 1'b0;
      wait_rv("to", rb);
      chk("to_latency", rv_cyc[rb] - acc_cyc, 9);
      chk("to_port", rv_port[rb], 0);
      chk("to_err", rv_err[rb], 1);
      chk("to_data", rv_data[rb], 0);
      stray_at = cyc + 5;
      step(12);
      chk("to_stray_ignored", rv_port.size() - rb, 1);
      // valid arriving on the timeout cycle
      resp_delay = TO + 1;
      rb = rv_port.size();
      p0_ren = 1'b1;
      wait_ack("coll");
      p0_ren = 1'b0;
      wait_rv("coll", rb);
      chk("coll_latency", rv_cyc[rb] - acc_cyc, 9);
      chk("coll_err", rv_err[rb], 0);
      chk("coll_data", rv_data[rb], 128'h0A);
      step(3);
      // async reset in the middle of a read wait
      resp_delay = 100000;
      p1_ren = 1'b1;
      wait_ack("arst");
      p1_ren = 1'b0;
      step(3);
      b = ack_log.size(); rb = rv_port.size();
      rstn = 1'b0; calib = 1'b0;
      #1 chk_zero("arst");
      step(2);
      rstn = 1'b1; p0_ren = 1'b1;
      stray_at = cyc + 2;
      step(10);
      chk("arst_no_ack", ack_log.size() - b, 0);
      chk("arst_no_rvalid", rv_port.size() - rb, 0);
      p0_ren = 1'b0;
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Shares the single DRAM user interface (ren/wen/addr/data/mask, busy, rdata/rdata_valid, init_calib_complete) between two requesters: port 0 = instruction-cache refill, port 1 = data/memory-mapped path.
- Round-robin arbitration, one command in flight at a time, read data routed back to the issuing port.
- Read watchdog converts a lost read into an error completion.
- Sits between the core's memory subsystem and the DRAM wrapper.

Parameters:
- APP_ADDR_WIDTH, 28, DRAM app address width; request and DRAM address ports are APP_ADDR_WIDTH-1 bits.
- APP_DATA_WIDTH, 128, DRAM burst data width.
- APP_MASK_WIDTH, 16, byte-write mask width (APP_DATA_WIDTH/8).
- RD_TIMEOUT, 1023, cycles in RWAIT before forced error completion (1..65535).

Ports:
- clk_166_67_mhz  in  1  block clock
- dram_rstx_async  in  1  asynchronous active-low reset
- pN_ren / pN_wen  in  1  read/write request, N=0,1; held until pN_ack; never both high
- pN_addr  in  APP_ADDR_WIDTH-1  request address
- pN_wdata  in  APP_DATA_WIDTH  write data
- pN_wmask  in  APP_MASK_WIDTH  write mask, passed through unmodified
- pN_ack  out  1  one-cycle pulse: request captured
- pN_rdata  out  APP_DATA_WIDTH  read data, valid with pN_rvalid
- pN_rvalid  out  1  one-cycle read completion
- pN_rerr  out  1  qualifies pN_rvalid: read timed out
- dram_ren / dram_wen  out  1  command to DRAM wrapper
- dram_addr / dram_wdata / dram_wmask  out  as above  command payload
- dram_init_calib_complete  in  1  DRAM calibrated
- dram_busy  in  1  command not accepted this cycle
- dram_rdata  in  APP_DATA_WIDTH  DRAM read data
- dram_rdata_valid  in  1  DRAM read data strobe

Behaviour:
- Interface: reset dram_rstx_async, asynchronous, active-low; clock clk_166_67_mhz. All flops are async-reset and all outputs are registered.
- Reset values: all acks, rvalids, rerrs, dram_ren and dram_wen are 0. Data, addr and mask outputs are 0. State = CALIB. last_grant = 1, so port 0 wins the first tie.
- FSM states: CALIB, IDLE, ISSUE, RWAIT.
- CALIB: no grants. Go to IDLE the cycle after dram_init_calib_complete is sampled high.
- IDLE, selection:
  - Pending(N) = pN_ren | pN_wen.
  - Only one pending: select it.
  - Both pending: select !last_grant.
- IDLE, capture: register addr, wdata, wmask, op and owner; set last_grant = owner; go to ISSUE.
- IDLE, calibration loss: if dram_init_calib_complete is low, return to CALIB. This is checked only in IDLE.
- ISSUE:
  - The first ISSUE cycle pulses p<owner>_ack.
  - dram_ren or dram_wen is held high with stable payload until a cycle with dram_busy = 0; that cycle is the acceptance.
  - After acceptance, a write returns to IDLE and a read goes to RWAIT with the timeout counter cleared.
  - Minimum occupancy is 1 cycle.
- RWAIT:
  - The counter increments each cycle.
  - When dram_rdata_valid = 1: next cycle, p<owner>_rdata = dram_rdata, p<owner>_rvalid = 1, rerr = 0; go to IDLE.
  - When the counter reaches RD_TIMEOUT with no valid: next cycle, rvalid = 1, rerr = 1, rdata = 0; go to IDLE.
  - If valid and timeout occur in the same cycle, valid wins and rerr = 0.
- Stray data: dram_rdata_valid outside RWAIT, including a late response after a timeout, is discarded and counted in no way.
- Output hold: pN_rdata holds its last value between completions. The non-owner port never sees rvalid.
- Throughput: minimum request-to-ack latency is 1 cycle. Back-to-back writes run at one per 2 cycles (IDLE, ISSUE).
- Requester rule: a requester deasserts or changes its request the cycle after ack. The arbiter does not re-sample until IDLE, so there is no double-grant.
- Reset mid-operation: everything asynchronously returns to reset values. An in-flight DRAM read is not completed.

Decomposition:
- Package dram_arb_pkg holds:
  - state enum arb_state_t {CALIB, IDLE, ISSUE, RWAIT};
  - port_id_t (1 bit);
  - op_t {OP_RD, OP_WR};
  - default width constants.
- One sub-module, dram_arb_rr2: 2-way round-robin selector (pending[1:0], last_grant -> valid, sel). Purely combinational; last_grant stays in the parent.

Test Plan:
- Calibration gate: calib held low for 50 cycles with p0_ren = 1 -> no ack and no dram_ren. Calib rises -> p0_ack 2 cycles later, dram_ren high with dram_addr = p0_addr.
- Contention: p0 and p1 both request reads continuously; DRAM returns rdata 3 cycles after acceptance -> acks alternate p0, p1, p0, p1. Each rvalid appears only on its owner, with rdata 0x...0A for p0 and 0x...0B for p1.
- Busy backpressure: p1 write (addr 0x123_4567, mask 0x00FF), dram_busy high for 5 cycles -> dram_wen and payload stable for 6 cycles, single acceptance, return to IDLE.
- Timeout: RD_TIMEOUT = 8, p0 read, no rdata_valid -> p0_rvalid = 1, p0_rerr = 1, rdata = 0 exactly 9 cycles after acceptance. A rdata_valid 5 cycles later is ignored with no pulse on either port.
- Collision: rdata_valid in the same cycle the counter hits RD_TIMEOUT -> rvalid with rerr = 0 and the data.
- Async reset: dram_rstx_async low mid-RWAIT -> all outputs 0 immediately, state CALIB. No rvalid after reset release.
